fact_bcd_conv: RTL and testbench
================================

Name: fact_bcd_conv

Overview:
- Downstream stage of the registered factorial unit: takes its 32-bit binary result and converts it to packed BCD for display/readout.
- Sequential shift-and-add-3 (double-dabble), one bit per clock.
- Valid/ready handshake on both sides, so it can sit between the factorial register and a display or serial-out stage.

Parameters:
- WIDTH, 32, binary input width (matches factorial result width)
- DIGITS, 10, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  upstream has a value on in_data
- in_ready  output  1  block can accept a value this cycle
- in_data  input  WIDTH  binary value to convert
- out_valid  output  1  out_bcd/out_digits hold a finished conversion
- out_ready  input  1  downstream accepts the result this cycle
- out_bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
- out_digits  output  4  count of significant digits, 1..DIGITS

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk.
  - While reset==0 at a rising edge: state=IDLE, in_ready=0, out_valid=0, out_bcd=0, shift/bcd work registers=0, bit counter=0.
  - in_ready goes to 1 on the first edge after reset is released.
  - Reset asserted mid-conversion or in DONE aborts immediately. No partial result is ever presented.
- States: IDLE, SHIFT, DONE. in_ready is high only in IDLE.
- IDLE:
  - in_valid && in_ready at an edge accepts the input:
    - bin_reg <= in_data
    - bcd_work <= 0
    - cnt <= WIDTH
    - next state SHIFT
  - in_data is sampled only on that edge; later changes are ignored.
- SHIFT (one iteration per edge):
  - For each digit of bcd_work, add 3 if the digit >= 5. This adjustment is combinational, applied before the shift.
  - Then shift {bcd_work, bin_reg} left by 1: bin_reg MSB enters bcd_work bit 0.
  - cnt decrements by 1.
  - When cnt==1 at the edge (last shift), the edge performs the final shift, loads out_bcd with the shifted value, sets out_valid=1, and moves to DONE.
- Latency: exactly WIDTH edges from the accepting edge to out_valid high (32 cycles at default).
- DONE:
  - out_valid=1; out_bcd and out_digits held stable.
  - On out_valid && out_ready at an edge: out_valid <= 0, next state IDLE.
  - out_bcd keeps its last value after the handshake, until the next conversion completes or reset.
- out_digits: combinational from out_bcd.
  - Equals the index of the highest nonzero digit + 1, or 1 when out_bcd==0.
  - Meaningful only while out_valid=1.
- No pipelining/overlap: a new input is accepted only in IDLE. Minimum period is WIDTH+2 cycles per value when out_ready is tied high.
- in_valid during SHIFT/DONE has no effect. Upstream must hold the value until in_ready.
- Arithmetic: each digit adjustment is a 4-bit add with no carry out (digit <= 9 is guaranteed). No overflow is possible for WIDTH=32, DIGITS=10.
- out_ready held high in IDLE/SHIFT has no effect.

Test Plan:
- Reset low 3 cycles, then release → out_valid=0, out_bcd=0; in_ready=1 one edge after release.
- in_data=120 (5!), out_ready=1 → out_valid high exactly 32 cycles after acceptance; out_bcd=40'h0000000120, out_digits=3; back in IDLE with in_ready=1 the cycle after.
- in_data=0 → out_bcd=0, out_digits=1. in_data=32'hFFFFFFFF → out_bcd=40'h4294967295, out_digits=10.
- in_data=3628800 (10!) with out_ready low for 5 cycles after out_valid → out_bcd=40'h0003628800 stable, out_digits=7, in_ready=0 throughout; handshake on cycle 6 clears out_valid.
- Back-to-back: in_valid held high with 1 then 479001600 (12!), out_ready=1 → results 40'h1 (digits 1) then 40'h0479001600 (digits 9); second acceptance occurs on the first IDLE cycle after the first handshake.
- Accept 40320 (8!), assert reset at shift 10 for 1 cycle → no out_valid; state IDLE, outputs 0; a new conversion of 24 then yields 40'h24, digits 2.

Source files
------------

// File: rtl/fact_bcd_conv.sv
// fact_bcd_conv: converts a binary factorial result to packed BCD.
// The conversion is shift-and-add-3 (double-dabble) and handles one bit per clock.
// There is a valid/ready handshake on both the input and output sides.
//
// state | meaning
// IDLE  | in_ready high, waiting to accept in_data
// SHIFT | one double-dabble iteration per edge, WIDTH edges in total
// DONE  | out_valid high, result held until out_ready
module fact_bcd_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_digits
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_bcd_work;
    logic [4*DIGITS-1:0]   r_out_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_bcd_next;
    logic [WIDTH-1:0]      w_bin_next;
    logic [3:0]            w_digits;

    // Add 3 to every BCD digit that is >= 5 before the shift.
    // A digit is never above 9 here, so the 4-bit sum cannot carry out.
    always_comb begin
        w_adj = r_bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd_work[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd_work[4*i +: 4] + 4'd3;
        end
    end

    assign w_bcd_next = {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
    assign w_bin_next = {r_bin[WIDTH-2:0], 1'b0};

    // The significant-digit count is the position of the highest nonzero digit plus one.
    // A result of zero still reports one digit.
    always_comb begin
        w_digits = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_out_bcd[4*i +: 4] != 4'd0)
                w_digits = 4'(i + 1);
        end
    end

    // Conversion FSM with registered handshake outputs.
    // Reset discards any conversion in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_bcd_work  <= '0;
            r_out_bcd   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_bin      <= in_data;
                        r_bcd_work <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_in_ready <= 1'b0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd_work <= w_bcd_next;
                    r_bin      <= w_bin_next;
                    r_cnt      <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_bcd   <= w_bcd_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_bcd    = r_out_bcd;
    assign out_digits = w_digits;

endmodule

// File: tb/tb_fact_bcd_conv.sv
// Testbench for fact_bcd_conv.
// A decimal reference model feeds a scoreboard.
// A separate monitor checks every output handshake against the scoreboard.
module tb_fact_bcd_conv;

    typedef struct {
        logic [39:0] bcd;
        logic [3:0]  dig;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready_w;
    logic [39:0] out_bcd;
    logic [3:0]  out_digits;

    logic        rand_mode = 1'b0;
    logic        rdy_fixed = 1'b1;
    logic        rnd_bit = 1'b0;
    int          cyc = 0;

    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sb_q[$];
    int          acc_q[$];

    fact_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready_w),
        .out_bcd    (out_bcd),
        .out_digits (out_digits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    assign out_ready_w = rand_mode ? rnd_bit : rdy_fixed;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t ref_model(input logic [31:0] v);
        exp_t e;
        longint unsigned x;
        int n;
        x = v;
        e.bcd = '0;
        for (int i = 0; i < 10; i++) begin
            e.bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        e.dig = 4'(n);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Watch the output side: latency on each rising out_valid, and result on each handshake.
    task automatic monitor();
        exp_t e;
        logic prev_ov;
        int   a;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (out_valid && !prev_ov) begin
                    if (acc_q.size() == 0) fail_now("unexpected_out_valid");
                    else begin
                        a = acc_q.pop_front();
                        chk("latency", 64'(cyc - a), 64'd32);
                    end
                end
                if (out_valid && out_ready_w) begin
                    if (sb_q.size() == 0) fail_now("unexpected_result");
                    else begin
                        e = sb_q.pop_front();
                        chk("out_bcd", 64'(out_bcd), 64'(e.bcd));
                        chk("out_digits", 64'(out_digits), 64'(e.dig));
                    end
                end
            end
            prev_ov = out_valid;
        end
    endtask

    // Present v and wait for acceptance.
    // The accept edge is recorded and the expected result is queued.
    task automatic send(input logic [31:0] v, output int acc);
        int k;
        in_data  = v;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        acc = -1;
        if (!in_ready) begin
            fail_now("accept_timeout");
        end else begin
            acc = cyc + 1;
            sb_q.push_back(ref_model(v));
            acc_q.push_back(acc);
            @(posedge clk); #1;
            in_data = $urandom();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int k;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int a1, a2;
        logic [31:0] facts [0:12];
        logic [31:0] v;
        facts = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720, 32'd5040,
                  32'd40320, 32'd362880, 32'd3628800, 32'd39916800, 32'd479001600};
        fork
            monitor();
            begin
                // Reset held for three cycles
                rdy_fixed = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_bcd", 64'(out_bcd), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                reset = 1'b1;
                @(posedge clk); #1;
                chk("in_ready_after_release", 64'(in_ready), 64'd1);

                // 5! with out_ready high
                send(32'd120, a1);
                wait_ov();
                chk("busy_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                chk("idle_in_ready", 64'(in_ready), 64'd1);
                chk("idle_out_valid", 64'(out_valid), 64'd0);
                chk("bcd_held_after_hs", 64'(out_bcd), 64'h120);

                // Boundaries: zero and all ones
                send(32'd0, a1);
                wait_ov();
                @(posedge clk); #1;
                send(32'hFFFF_FFFF, a1);
                wait_ov();
                @(posedge clk); #1;

                // 10! with the output stalled for five cycles
                rdy_fixed = 1'b0;
                send(32'd3628800, a1);
                wait_ov();
                for (int i = 0; i < 5; i++) begin
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_bcd", 64'(out_bcd), 64'h0003628800);
                    chk("stall_digits", 64'(out_digits), 64'd7);
                    @(posedge clk); #1;
                end
                rdy_fixed = 1'b1;
                @(posedge clk); #1;
                chk("stall_release", 64'(out_valid), 64'd0);

                // Back-to-back: 1 then 12!
                send(32'd1, a1);
                send(32'd479001600, a2);
                chk("b2b_accept_spacing", 64'(a2 - a1), 64'd34);
                wait_ov();
                @(posedge clk); #1;

                // Reset during the tenth shift of 8!
                send(32'd40320, a1);
                repeat (9) begin
                    @(posedge clk); #1;
                end
                reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                sb_q.delete();
                acc_q.delete();
                chk("abort_out_valid", 64'(out_valid), 64'd0);
                chk("abort_out_bcd", 64'(out_bcd), 64'd0);
                chk("abort_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                chk("abort_idle_ready", 64'(in_ready), 64'd1);
                repeat (40) begin
                    @(posedge clk); #1;
                end
                send(32'd24, a1);
                wait_ov();
                @(posedge clk); #1;

                // Randomized values with random output backpressure
                rand_mode = 1'b1;
                for (int n = 0; n < 30; n++) begin
                    case ($urandom_range(0, 3))
                        0: v = $urandom();
                        1: v = $urandom_range(0, 999);
                        2: v = facts[$urandom_range(0, 12)];
                        default: v = ($urandom_range(0, 1) == 1) ? 32'd999999999 : 32'd1000000000;
                    endcase
                    send(v, a1);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                drain();
                rand_mode = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
